l2dr_req_arb: RTL and testbench
===============================

L2DR_REQ_ARB -- requirements
Module: l2dr_req_arb

Interface
REQ-001 Parameter ARB_WEIGHT_L2, default 2: maximum consecutive L2 grants while an L2TLB request waits (legal range 1..7).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 l2_req_valid / l2_req_retry / l2_req  in / out / in  1 / 1 / $bits(I_l2todr_req_type)  request from L2 cache.
REQ-005 tlb_req_valid / tlb_req_retry / tlb_req  in / out / in  1 / 1 / $bits(I_l2todr_req_type)  request from L2TLB.
REQ-006 l2todr_req_valid / l2todr_req_retry / l2todr_req  out / in / out  1 / 1 / $bits(I_l2todr_req_type)  merged request to directory.
REQ-007 drtol2_snack_valid / drtol2_snack_retry / drtol2_snack  in / out / in  1 / 1 / $bits(I_drtol2_snack_type)  snoop/ack from directory.
REQ-008 l2_snack_valid / l2_snack_retry / l2_snack  out / in / out  1 / 1 / $bits(I_drtol2_snack_type)  snack routed to L2.
REQ-009 tlb_snack_valid / tlb_snack_retry / tlb_snack  out / in / out  1 / 1 / $bits(I_drtol2_snack_type)  snack routed to L2TLB.

Function
REQ-010 All channels SHALL use valid/retry: a transfer occurs in a cycle with valid=1 and retry=0; the sender holds valid and payload stable while retry=1.
REQ-011 Request path SHALL use a 2-entry FIFO (count 0..2) ahead of l2todr_req; l2todr_req_valid = count!=0, payload = FIFO head.
REQ-012 Grants SHALL be issued only when count<2, with l2_req_retry/tlb_req_retry derived from registered state and the grant only, never from l2todr_req_retry combinationally.
REQ-013 Simultaneous enqueue and dequeue at count=2 SHALL NOT occur (full blocks grants); at count=1 both SHALL occur and count stays 1.
REQ-014 Minimum latency from input transfer to l2todr_req_valid SHALL be 1 cycle.
REQ-015 Arbitration SHALL use a 3-bit streak counter: both valid -> grant L2 if streak<ARB_WEIGHT_L2 (streak+1), else grant TLB (streak=0).
REQ-016 Only L2 valid -> grant L2, streak=0; only TLB valid -> grant TLB, streak=0; neither valid or FIFO full -> no grant, streak unchanged.
REQ-017 Exactly one source SHALL be granted per cycle; the ungranted valid source sees retry=1.
REQ-018 Snack path SHALL route by drtol2_snack.nid[0]: 0 -> L2 output, 1 -> TLB output, each through its own 1-entry output register.
REQ-019 drtol2_snack_retry SHALL be 1 when the selected destination register is full and its retry is 1; a register accepts when empty or drained in the same cycle.
REQ-020 A blocked destination SHALL stall the whole snack stream (in-order, no bypass); snack latency SHALL be 1 cycle.

Reset
REQ-021 While reset=0: FIFO count=0, streak=0, both snack registers empty; all *_valid outputs=0, l2_req_retry=tlb_req_retry=0, drtol2_snack_retry=0.
REQ-022 Reset asserted mid-operation SHALL discard all buffered requests and snacks; no partial transfer is emitted after release.

Configuration
REQ-023 With L2DR_ARB_NID_STAMP_EN defined, nid[0] of every enqueued request SHALL be overwritten with source (L2=0, TLB=1); without it, nid passes through unmodified.

Structure
REQ-024 Constants L2DR_NID_L2=1'b0 and L2DR_NID_TLB=1'b1 SHALL live in the shared package beside I_l2todr_req_type and I_drtol2_snack_type.
REQ-025 The 2-entry request FIFO SHALL be a sub-module named l2dr_arb_fifo2; arbitration and snack routing stay in l2dr_req_arb.

Verification
REQ-026 Both sources valid continuously, downstream retry=0, ARB_WEIGHT_L2=2 -> output order L2,L2,TLB,L2,L2,TLB...
REQ-027 Only TLB valid with nid=0x4, macro defined -> l2todr_req.nid=0x5 one cycle later; macro undefined -> nid=0x4.
REQ-028 l2todr_req_retry=1 for 5 cycles with both sources valid -> exactly 2 requests accepted, then both inputs see retry=1 until a dequeue.
REQ-029 Snack nid=0x3 while tlb_snack_retry=1 and TLB register full -> drtol2_snack_retry=1; a following nid=0x2 snack is not delivered to L2 until TLB drains.
REQ-030 reset driven low with FIFO count=2 -> next cycle l2todr_req_valid=0, streak=0; first post-reset request appears after 1 cycle.

Source files
------------

// File: rtl/l2dr_req_arb_pkg.sv
// Shared types and constants for the L2/L2TLB to directory request arbiter.
package l2dr_req_arb_pkg;

    localparam int L2DR_NID_W  = 5;
    localparam int L2DR_ADDR_W = 16;
    localparam int L2DR_DATA_W = 16;

    // Source identifiers carried in nid[0]
    localparam logic L2DR_NID_L2  = 1'b0;
    localparam logic L2DR_NID_TLB = 1'b1;

    typedef struct packed {
        logic [L2DR_NID_W-1:0]  nid;
        logic [L2DR_ADDR_W-1:0] addr;
        logic [2:0]             cmd;
    } I_l2todr_req_type;

    typedef struct packed {
        logic [L2DR_NID_W-1:0]  nid;
        logic [L2DR_DATA_W-1:0] data;
    } I_drtol2_snack_type;

    // Overwrite the low node-id bit with the granted source
    function automatic I_l2todr_req_type stamp_nid(input I_l2todr_req_type req,
                                                   input logic src);
        I_l2todr_req_type r;
        r        = req;
        r.nid[0] = src;
        return r;
    endfunction

endpackage

// File: rtl/l2dr_arb_fifo2.sv
// Two-entry request FIFO; entry 0 is always the head, entry 1 the tail.
// A push at count=2 is ignored, and a pop at count=0 is ignored.
module l2dr_arb_fifo2
    import l2dr_req_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  I_l2todr_req_type push_data,
    input  logic             pop,
    output I_l2todr_req_type head,
    output logic [1:0]       count,
    output logic             full
);

    I_l2todr_req_type ent0_q, ent0_d;
    I_l2todr_req_type ent1_q, ent1_d;
    logic [1:0]       count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign head  = ent0_q;
    assign count = count_q;
    assign full  = (count_q == 2'd2);

    // Next-state for the shift-style storage and occupancy count
    always_comb begin
        do_push = push && (count_q != 2'd2);
        do_pop  = pop && (count_q != 2'd0);
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) ent0_d = push_data;
                else                 ent1_d = push_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable at count=1: head leaves, new entry becomes head
                ent0_d = push_data;
            end
            default: ;
        endcase
    end

    // Storage and count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/l2dr_req_arb.sv
// L2 / L2TLB request arbiter toward the directory plus snack demultiplexer.
// Optional feature: define L2DR_ARB_NID_STAMP_EN to stamp nid[0] of every
// enqueued request with its source (L2=0, TLB=1).
//
// Handshake (all channels): a transfer happens in a cycle where valid=1 and
// retry=0; the sender keeps valid and payload stable while retry=1.
module l2dr_req_arb
    import l2dr_req_arb_pkg::*;
#(
    parameter int unsigned ARB_WEIGHT_L2 = 2
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               l2_req_valid,
    output logic               l2_req_retry,
    input  I_l2todr_req_type   l2_req,

    input  logic               tlb_req_valid,
    output logic               tlb_req_retry,
    input  I_l2todr_req_type   tlb_req,

    output logic               l2todr_req_valid,
    input  logic               l2todr_req_retry,
    output I_l2todr_req_type   l2todr_req,

    input  logic               drtol2_snack_valid,
    output logic               drtol2_snack_retry,
    input  I_drtol2_snack_type drtol2_snack,

    output logic               l2_snack_valid,
    input  logic               l2_snack_retry,
    output I_drtol2_snack_type l2_snack,

    output logic               tlb_snack_valid,
    input  logic               tlb_snack_retry,
    output I_drtol2_snack_type tlb_snack,

    output logic [2:0]         dbg_streak,
    output logic [1:0]         dbg_fifo_count
);

    localparam logic [2:0] STREAK_MAX = 3'(ARB_WEIGHT_L2);

    // ---------------- request arbitration ----------------
    logic             fifo_full;
    logic [1:0]       fifo_count;
    I_l2todr_req_type fifo_head;
    I_l2todr_req_type enq_data;
    logic             arb_en;
    logic             grant_l2;
    logic             grant_tlb;
    logic [2:0]       streak_q, streak_d;

    // Grants depend only on registered FIFO state, the input valids and reset
    assign arb_en = reset && !fifo_full;

    // Weighted choice between sources; streak counts back-to-back contested L2 wins
    always_comb begin
        grant_l2  = 1'b0;
        grant_tlb = 1'b0;
        streak_d  = streak_q;
        if (arb_en) begin
            if (l2_req_valid && tlb_req_valid) begin
                if (streak_q < STREAK_MAX) begin
                    grant_l2 = 1'b1;
                    streak_d = streak_q + 3'd1;
                end else begin
                    grant_tlb = 1'b1;
                    streak_d  = 3'd0;
                end
            end else if (l2_req_valid) begin
                grant_l2 = 1'b1;
                streak_d = 3'd0;
            end else if (tlb_req_valid) begin
                grant_tlb = 1'b1;
                streak_d  = 3'd0;
            end
        end
    end

    // Streak register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) streak_q <= 3'd0;
        else        streak_q <= streak_d;
    end

    assign l2_req_retry  = reset && l2_req_valid && !grant_l2;
    assign tlb_req_retry = reset && tlb_req_valid && !grant_tlb;

    // Select the granted payload, optionally tagging its source in nid[0]
    always_comb begin
`ifdef L2DR_ARB_NID_STAMP_EN
        enq_data = grant_tlb ? stamp_nid(tlb_req, L2DR_NID_TLB)
                             : stamp_nid(l2_req, L2DR_NID_L2);
`else
        enq_data = grant_tlb ? tlb_req : l2_req;
`endif
    end

    l2dr_arb_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant_l2 || grant_tlb),
        .push_data (enq_data),
        .pop       (l2todr_req_valid && !l2todr_req_retry),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    assign l2todr_req_valid = (fifo_count != 2'd0);
    assign l2todr_req       = fifo_head;
    assign dbg_streak       = streak_q;
    assign dbg_fifo_count   = fifo_count;

    // ---------------- snack routing ----------------
    logic               snk_to_tlb;
    logic               l2_snk_open;
    logic               tlb_snk_open;
    logic               snk_accept;
    logic               l2_snk_valid_q, l2_snk_valid_d;
    logic               tlb_snk_valid_q, tlb_snk_valid_d;
    I_drtol2_snack_type l2_snk_q, l2_snk_d;
    I_drtol2_snack_type tlb_snk_q, tlb_snk_d;

    // A destination register can take a snack when empty or draining this cycle.
    // The input stream stalls as a whole when its head's destination is blocked.
    assign snk_to_tlb   = drtol2_snack.nid[0];
    assign l2_snk_open  = !l2_snk_valid_q || !l2_snack_retry;
    assign tlb_snk_open = !tlb_snk_valid_q || !tlb_snack_retry;
    assign drtol2_snack_retry = drtol2_snack_valid &&
                                (snk_to_tlb ? !tlb_snk_open : !l2_snk_open);
    assign snk_accept   = drtol2_snack_valid && !drtol2_snack_retry;

    // Next-state of both single-entry snack output registers
    always_comb begin
        l2_snk_valid_d  = l2_snk_valid_q;
        l2_snk_d        = l2_snk_q;
        tlb_snk_valid_d = tlb_snk_valid_q;
        tlb_snk_d       = tlb_snk_q;
        if (l2_snk_valid_q && !l2_snack_retry)   l2_snk_valid_d  = 1'b0;
        if (tlb_snk_valid_q && !tlb_snack_retry) tlb_snk_valid_d = 1'b0;
        if (snk_accept && !snk_to_tlb) begin
            l2_snk_valid_d = 1'b1;
            l2_snk_d       = drtol2_snack;
        end
        if (snk_accept && snk_to_tlb) begin
            tlb_snk_valid_d = 1'b1;
            tlb_snk_d       = drtol2_snack;
        end
    end

    // Snack output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l2_snk_valid_q  <= 1'b0;
            l2_snk_q        <= '0;
            tlb_snk_valid_q <= 1'b0;
            tlb_snk_q       <= '0;
        end else begin
            l2_snk_valid_q  <= l2_snk_valid_d;
            l2_snk_q        <= l2_snk_d;
            tlb_snk_valid_q <= tlb_snk_valid_d;
            tlb_snk_q       <= tlb_snk_d;
        end
    end

    assign l2_snack_valid  = l2_snk_valid_q;
    assign l2_snack        = l2_snk_q;
    assign tlb_snack_valid = tlb_snk_valid_q;
    assign tlb_snack       = tlb_snk_q;

endmodule

// File: tb/tb_l2dr_req_arb.sv
// Directed bench for l2dr_req_arb with queue-based scoreboards for the
// request output and both snack outputs.
module tb_l2dr_req_arb;
    import l2dr_req_arb_pkg::*;

    logic               clk;
    logic               reset;
    logic               l2_req_valid, l2_req_retry;
    I_l2todr_req_type   l2_req;
    logic               tlb_req_valid, tlb_req_retry;
    I_l2todr_req_type   tlb_req;
    logic               l2todr_req_valid, l2todr_req_retry;
    I_l2todr_req_type   l2todr_req;
    logic               drtol2_snack_valid, drtol2_snack_retry;
    I_drtol2_snack_type drtol2_snack;
    logic               l2_snack_valid, l2_snack_retry;
    I_drtol2_snack_type l2_snack;
    logic               tlb_snack_valid, tlb_snack_retry;
    I_drtol2_snack_type tlb_snack;
    logic [2:0]         dbg_streak;
    logic [1:0]         dbg_fifo_count;

    localparam int RW = $bits(I_l2todr_req_type);
    localparam int SW = $bits(I_drtol2_snack_type);

    int n_cmp = 0;
    int n_err = 0;
    int acc_l2 = 0;
    int acc_tlb = 0;
    logic [RW-1:0] exp_q[$];
    logic [SW-1:0] exp_l2s_q[$];
    logic [SW-1:0] exp_tlbs_q[$];

    l2dr_req_arb #(.ARB_WEIGHT_L2(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .l2_req_valid       (l2_req_valid),
        .l2_req_retry       (l2_req_retry),
        .l2_req             (l2_req),
        .tlb_req_valid      (tlb_req_valid),
        .tlb_req_retry      (tlb_req_retry),
        .tlb_req            (tlb_req),
        .l2todr_req_valid   (l2todr_req_valid),
        .l2todr_req_retry   (l2todr_req_retry),
        .l2todr_req         (l2todr_req),
        .drtol2_snack_valid (drtol2_snack_valid),
        .drtol2_snack_retry (drtol2_snack_retry),
        .drtol2_snack       (drtol2_snack),
        .l2_snack_valid     (l2_snack_valid),
        .l2_snack_retry     (l2_snack_retry),
        .l2_snack           (l2_snack),
        .tlb_snack_valid    (tlb_snack_valid),
        .tlb_snack_retry    (tlb_snack_retry),
        .tlb_snack          (tlb_snack),
        .dbg_streak         (dbg_streak),
        .dbg_fifo_count     (dbg_fifo_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    function automatic I_l2todr_req_type mk_l2(input int i);
        I_l2todr_req_type r;
        r.nid  = 5'h09;
        r.addr = 16'h1000 + i[15:0];
        r.cmd  = 3'd1;
        return r;
    endfunction

    function automatic I_l2todr_req_type mk_tlb(input int i);
        I_l2todr_req_type r;
        r.nid  = 5'h04;
        r.addr = 16'h2000 + i[15:0];
        r.cmd  = 3'd2;
        return r;
    endfunction

    function automatic I_l2todr_req_type exp_l2(input int i);
        I_l2todr_req_type r;
        r = mk_l2(i);
`ifdef L2DR_ARB_NID_STAMP_EN
        r.nid = 5'h08;
`endif
        return r;
    endfunction

    function automatic I_l2todr_req_type exp_tlb(input int i);
        I_l2todr_req_type r;
        r = mk_tlb(i);
`ifdef L2DR_ARB_NID_STAMP_EN
        r.nid = 5'h05;
`endif
        return r;
    endfunction

    // ---------------- drivers ----------------
    // Drive both request sources until n_l2 / n_tlb transfers each; starts at posedge+1
    task automatic run_sources(input int n_l2, input int n_tlb, input int base);
        int li = 0;
        int ti = 0;
        int budget = 0;
        bit l2_fire;
        bit tlb_fire;
        while ((li < n_l2 || ti < n_tlb) && budget < 200) begin
            l2_req_valid  = (li < n_l2);
            l2_req        = mk_l2(base + li);
            tlb_req_valid = (ti < n_tlb);
            tlb_req       = mk_tlb(base + ti);
            @(negedge clk);
            l2_fire  = l2_req_valid && !l2_req_retry;
            tlb_fire = tlb_req_valid && !tlb_req_retry;
            if (l2_req_valid && tlb_req_valid && dbg_fifo_count != 2'd2)
                check("one_grant", {31'b0, l2_req_retry ^ tlb_req_retry}, 32'd1);
            @(posedge clk); #1;
            if (l2_fire)  begin li++; acc_l2++;  end
            if (tlb_fire) begin ti++; acc_tlb++; end
            budget++;
        end
        if (budget >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL run_sources_timeout: got %0d/%0d, want %0d/%0d", li, ti, n_l2, n_tlb);
        end
        l2_req_valid  = 1'b0;
        tlb_req_valid = 1'b0;
    endtask

    // Present one snack and hold it until accepted; starts at posedge+1
    task automatic send_snack(input logic [4:0] nid, input logic [15:0] data);
        I_drtol2_snack_type s;
        int budget = 0;
        bit done = 1'b0;
        s.nid  = nid;
        s.data = data;
        if (nid[0]) exp_tlbs_q.push_back(s);
        else        exp_l2s_q.push_back(s);
        drtol2_snack_valid = 1'b1;
        drtol2_snack       = s;
        while (!done && budget < 100) begin
            @(negedge clk);
            done = !drtol2_snack_retry;
            @(posedge clk); #1;
            budget++;
        end
        drtol2_snack_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL send_snack_timeout: got retry, want accept of nid 0x%0h", nid);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (reset && l2todr_req_valid && !l2todr_req_retry) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL req_unexpected: got 0x%0h, want none", l2todr_req);
            end else begin
                check("req_payload", 32'(l2todr_req), 32'(exp_q.pop_front()));
            end
        end
        if (reset && l2_snack_valid && !l2_snack_retry) begin
            if (exp_l2s_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL l2_snack_unexpected: got 0x%0h, want none", l2_snack);
            end else begin
                check("l2_snack_payload", 32'(l2_snack), 32'(exp_l2s_q.pop_front()));
            end
        end
        if (reset && tlb_snack_valid && !tlb_snack_retry) begin
            if (exp_tlbs_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL tlb_snack_unexpected: got 0x%0h, want none", tlb_snack);
            end else begin
                check("tlb_snack_payload", 32'(tlb_snack), 32'(exp_tlbs_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wait_cnt;
        reset              = 1'b0;
        l2_req_valid       = 1'b1;
        l2_req             = mk_l2(0);
        tlb_req_valid      = 1'b1;
        tlb_req            = mk_tlb(0);
        l2todr_req_retry   = 1'b0;
        drtol2_snack_valid = 1'b1;
        drtol2_snack       = '0;
        l2_snack_retry     = 1'b0;
        tlb_snack_retry    = 1'b0;

        // Reset state, with all inputs active to show retries stay low
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", {31'b0, l2todr_req_valid}, 32'd0);
        check("rst_l2_snack_valid", {31'b0, l2_snack_valid}, 32'd0);
        check("rst_tlb_snack_valid", {31'b0, tlb_snack_valid}, 32'd0);
        check("rst_l2_retry", {31'b0, l2_req_retry}, 32'd0);
        check("rst_tlb_retry", {31'b0, tlb_req_retry}, 32'd0);
        check("rst_snack_retry", {31'b0, drtol2_snack_retry}, 32'd0);
        check("rst_count", {30'b0, dbg_fifo_count}, 32'd0);
        check("rst_streak", {29'b0, dbg_streak}, 32'd0);
        l2_req_valid       = 1'b0;
        tlb_req_valid      = 1'b0;
        drtol2_snack_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Weighted order with both sources continuously valid: L2,L2,TLB repeating
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(exp_l2(2 * k));
            exp_q.push_back(exp_l2(2 * k + 1));
            exp_q.push_back(exp_tlb(k));
        end
        run_sources(6, 3, 0);
        repeat (3) @(posedge clk); #1;
        check("streak_after_order", {29'b0, dbg_streak}, 32'd0);

        // Single TLB request: nid stamping and one-cycle latency
        exp_q.push_back(exp_tlb(50));
        tlb_req_valid = 1'b1;
        tlb_req       = mk_tlb(50);
        @(negedge clk);
        check("tlb_single_retry", {31'b0, tlb_req_retry}, 32'd0);
        @(posedge clk); #1;
        tlb_req_valid = 1'b0;
        @(negedge clk);
        check("tlb_latency_valid", {31'b0, l2todr_req_valid}, 32'd1);
`ifdef L2DR_ARB_NID_STAMP_EN
        check("tlb_nid", {27'b0, l2todr_req.nid}, 32'h5);
`else
        check("tlb_nid", {27'b0, l2todr_req.nid}, 32'h4);
`endif
        @(posedge clk); #1;
        repeat (2) @(posedge clk); #1;

        // Downstream stalled: FIFO fills with two, then both sources see retry
        acc_l2  = 0;
        acc_tlb = 0;
        exp_q.push_back(exp_l2(100));
        exp_q.push_back(exp_l2(101));
        exp_q.push_back(exp_tlb(100));
        exp_q.push_back(exp_l2(102));
        exp_q.push_back(exp_l2(103));
        exp_q.push_back(exp_tlb(101));
        l2todr_req_retry = 1'b1;
        fork
            run_sources(4, 2, 100);
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("stall_accepted", 32'(acc_l2 + acc_tlb), 32'd2);
                check("stall_count", {30'b0, dbg_fifo_count}, 32'd2);
                check("stall_l2_retry", {31'b0, l2_req_retry}, 32'd1);
                check("stall_tlb_retry", {31'b0, tlb_req_retry}, 32'd1);
                @(posedge clk); #1;
                l2todr_req_retry = 1'b0;
            end
        join
        repeat (3) @(posedge clk); #1;

        // Snack path: blocked TLB register stalls the whole stream
        tlb_snack_retry = 1'b1;
        fork
            begin
                send_snack(5'h03, 16'hA001);
                send_snack(5'h03, 16'hA002);
                send_snack(5'h02, 16'hB001);
            end
            begin
                repeat (2) @(posedge clk);
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("snack_blocked_retry", {31'b0, drtol2_snack_retry}, 32'd1);
                    check("snack_no_l2_bypass", {31'b0, l2_snack_valid}, 32'd0);
                end
                @(posedge clk); #1;
                tlb_snack_retry = 1'b0;
            end
        join
        repeat (2) @(posedge clk); #1;

        // Snack latency to the L2 side
        send_snack(5'h06, 16'hC001);
        @(negedge clk);
        check("l2_snack_latency", {31'b0, l2_snack_valid}, 32'd1);
        @(posedge clk); #1;
        repeat (2) @(posedge clk); #1;

        // Reset with a full FIFO discards its contents
        l2todr_req_retry = 1'b1;
        l2_req_valid     = 1'b1;
        l2_req           = mk_l2(300);
        tlb_req_valid    = 1'b1;
        tlb_req          = mk_tlb(300);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("prerst_count", {30'b0, dbg_fifo_count}, 32'd2);
        check("prerst_streak", {29'b0, dbg_streak}, 32'd2);
        reset = 1'b0;
        #1;
        check("midrst_req_valid", {31'b0, l2todr_req_valid}, 32'd0);
        check("midrst_count", {30'b0, dbg_fifo_count}, 32'd0);
        check("midrst_streak", {29'b0, dbg_streak}, 32'd0);
        check("midrst_l2_retry", {31'b0, l2_req_retry}, 32'd0);
        @(negedge clk);
        check("midrst_req_valid_next", {31'b0, l2todr_req_valid}, 32'd0);
        l2_req_valid     = 1'b0;
        tlb_req_valid    = 1'b0;
        l2todr_req_retry = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.push_back(exp_l2(200));
        l2_req_valid = 1'b1;
        l2_req       = mk_l2(200);
        @(negedge clk);
        check("postrst_no_stale", {31'b0, l2todr_req_valid}, 32'd0);
        @(posedge clk); #1;
        l2_req_valid = 1'b0;
        @(negedge clk);
        check("postrst_latency", {31'b0, l2todr_req_valid}, 32'd1);
        @(posedge clk); #1;

        // Drain and confirm every expected item was observed
        wait_cnt = 0;
        while ((exp_q.size() != 0 || exp_l2s_q.size() != 0 || exp_tlbs_q.size() != 0)
               && wait_cnt < 50) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check("req_queue_empty", 32'(exp_q.size()), 32'd0);
        check("l2_snack_queue_empty", 32'(exp_l2s_q.size()), 32'd0);
        check("tlb_snack_queue_empty", 32'(exp_tlbs_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
